// File: rtl/disp_pkg.sv
// Shared display constants and digit-vector type for the 7-segment scan path.
package disp_pkg;
    localparam int unsigned DEFAULT_DIV   = 100000;
    localparam int unsigned DEFAULT_BLANK = 1000;
    localparam int unsigned NUM_DIGITS    = 4;
    localparam int unsigned NIB_W         = 4;
    localparam int unsigned RC_W          = $clog2(NUM_DIGITS);
    localparam int unsigned VALUE_W       = NUM_DIGITS * NIB_W;

    typedef logic [NUM_DIGITS-1:0][NIB_W-1:0] digits_t;

    // Nibble shown in digit slot rc.
    function automatic logic [NIB_W-1:0] digit_sel(input digits_t d, input logic [RC_W-1:0] rc);
        return d[rc];
    endfunction
endpackage

// File: rtl/refresh_scan_if.sv
// Scan control, value load and display outputs of the refresh sequencer.
interface refresh_scan_if;
    import disp_pkg::*;

    logic                en;
    digits_t             value;
    logic                value_load;
    logic [RC_W-1:0]     refreshcounter;
    logic [NIB_W-1:0]    nibble;
    logic                blank;
    logic                frame_tick;
    logic                pending;

    modport master (
        output en, value, value_load,
        input  refreshcounter, nibble, blank, frame_tick, pending
    );

    modport slave (
        input  en, value, value_load,
        output refreshcounter, nibble, blank, frame_tick, pending
    );
endinterface

// File: rtl/slot_timer.sv
// Per-slot cycle counter: wrap strobe plus a blank flag aligned with the count.
module slot_timer #(
    parameter int unsigned DIV   = 100000,
    parameter int unsigned BLANK = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    output logic o_blank,
    output logic o_slot_end_c
);
    localparam int unsigned CW = (DIV > 2) ? $clog2(DIV) : 1;

    if (DIV < 2 || BLANK >= DIV) begin : g_param_check
        $error("slot_timer: DIV must be >= 2 and BLANK < DIV");
    end

    logic [CW-1:0] r_c;
    logic [CW-1:0] w_c_next;
    logic          w_wrap;
    logic          w_in_blank;

    always_comb begin
        w_wrap   = i_en && (r_c == CW'(DIV - 1));
        w_c_next = r_c;
        if (i_en) begin
            w_c_next = w_wrap ? '0 : r_c + CW'(1);
        end
    end

    // Blank window is judged on the count the register is about to hold.
    if (BLANK == 0) begin : g_no_blank
        assign w_in_blank = 1'b0;
    end else begin : g_blank
        assign w_in_blank = (32'(w_c_next) < BLANK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_c     <= '0;
            o_blank <= 1'b1;
        end else begin
            r_c     <= w_c_next;
            o_blank <= !i_en || w_in_blank;
        end
    end

    assign o_slot_end_c = w_wrap;
endmodule

// File: rtl/refresh_scan.sv
// Digit scan sequencer with double-buffered display value swapped on frame boundaries.
module refresh_scan
    import disp_pkg::*;
#(
    parameter int unsigned DIV   = DEFAULT_DIV,
    parameter int unsigned BLANK = DEFAULT_BLANK
) (
    input  logic           clk,
    input  logic           rst,
    refresh_scan_if.slave  bus
);
    logic             w_slot_end;
    logic             w_blank;
    logic             w_boundary;
    logic [RC_W-1:0]  w_rc_next;
    digits_t          w_shadow_next;

    logic [RC_W-1:0]  r_rc;
    digits_t          r_shadow;
    digits_t          r_pend;
    logic             r_pending;
    logic             r_frame_tick;
    logic [NIB_W-1:0] r_nibble;

    slot_timer #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_slot_timer (
        .clk          (clk),
        .rst          (rst),
        .i_en         (bus.en),
        .o_blank      (w_blank),
        .o_slot_end_c (w_slot_end)
    );

    // A load landing on the boundary itself bypasses the pending buffer.
    always_comb begin
        w_boundary    = w_slot_end && (r_rc == RC_W'(NUM_DIGITS - 1));
        w_rc_next     = w_slot_end ? r_rc + RC_W'(1) : r_rc;
        w_shadow_next = r_shadow;
        if (w_boundary) begin
            if (bus.value_load) begin
                w_shadow_next = bus.value;
            end else if (r_pending) begin
                w_shadow_next = r_pend;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rc         <= '0;
            r_shadow     <= '0;
            r_pend       <= '0;
            r_pending    <= 1'b0;
            r_frame_tick <= 1'b0;
            r_nibble     <= '0;
        end else begin
            r_rc         <= w_rc_next;
            r_shadow     <= w_shadow_next;
            r_frame_tick <= w_boundary;
            r_nibble     <= digit_sel(w_shadow_next, w_rc_next);
            if (bus.value_load) begin
                r_pend    <= bus.value;
                r_pending <= !w_boundary;
            end else if (w_boundary) begin
                r_pending <= 1'b0;
            end
        end
    end

    assign bus.refreshcounter = r_rc;
    assign bus.nibble         = r_nibble;
    assign bus.blank          = w_blank;
    assign bus.frame_tick     = r_frame_tick;
    assign bus.pending        = r_pending;
endmodule

// File: tb/tb_refresh_scan.sv
// Directed bench for refresh_scan at DIV=8, BLANK=2, with a BLANK=0 twin sharing the inputs.
module tb_refresh_scan;
    import disp_pkg::*;

    localparam int unsigned DIV   = 8;
    localparam int unsigned BLANK = 2;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        en         = 1'b1;
    logic        value_load = 1'b0;
    logic [15:0] value      = 16'h0000;

    int ntests = 0;
    int nfail  = 0;

    refresh_scan_if bus  ();
    refresh_scan_if bus0 ();

    assign bus.en          = en;
    assign bus.value       = value;
    assign bus.value_load  = value_load;
    assign bus0.en         = en;
    assign bus0.value      = value;
    assign bus0.value_load = value_load;

    refresh_scan #(.DIV(DIV), .BLANK(BLANK)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    refresh_scan #(.DIV(DIV), .BLANK(0)) dut_b0 (
        .clk (clk),
        .rst (rst),
        .bus (bus0)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input int rc, input int nib,
                           input bit bl, input bit ft, input bit pd);
        chk({tag, ".rc"},    32'(bus.refreshcounter), 32'(rc));
        chk({tag, ".nib"},   32'(bus.nibble),         32'(nib));
        chk({tag, ".blank"}, 32'(bus.blank),          32'(bl));
        chk({tag, ".tick"},  32'(bus.frame_tick),     32'(ft));
        chk({tag, ".pend"},  32'(bus.pending),        32'(pd));
    endtask

    initial begin
        // Reset state; cycle 0 is the first cycle after the last reset edge.
        tick(3);
        chk_out("reset", 0, 0, 1'b1, 1'b0, 1'b0);
        chk("reset.b0blank", 32'(bus0.blank), 32'(1));
        rst = 1'b0;

        // Free-running scan with value 0: slots every 8 cycles, ticks at 32 and 64.
        for (int k = 1; k <= 65; k++) begin
            tick(1);
            chk_out($sformatf("scan%0d", k), (k / 8) % 4, 0, (k % 8) < 2,
                    (k == 32) || (k == 64), 1'b0);
            chk($sformatf("scan%0d.b0blank", k), 32'(bus0.blank), 32'(0));
        end

        // Mid-frame load at cycle 65, shown after boundary at cycle 95.
        value = 16'hA5C3; value_load = 1'b1;
        tick(1);
        value_load = 1'b0;
        chk_out("ld_pend", 0, 0, 1'b0, 1'b0, 1'b1);
        tick(29);
        chk_out("ld_pre_bnd", 3, 0, 1'b0, 1'b0, 1'b1);
        tick(1);
        chk_out("ld_slot0", 0, 4'h3, 1'b1, 1'b1, 1'b0);
        tick(8);
        chk_out("ld_slot1", 1, 4'hC, 1'b1, 1'b0, 1'b0);
        tick(8);
        chk_out("ld_slot2", 2, 4'h5, 1'b1, 1'b0, 1'b0);
        tick(8);
        chk_out("ld_slot3", 3, 4'hA, 1'b1, 1'b0, 1'b0);

        // Two loads in one frame: last one wins at the boundary (cycle 127).
        value = 16'h1111; value_load = 1'b1;
        tick(1);
        chk("dbl_pend1", 32'(bus.pending), 32'(1));
        value = 16'h2222;
        tick(1);
        value_load = 1'b0;
        chk_out("dbl_pend2", 3, 4'hA, 1'b0, 1'b0, 1'b1);
        tick(6);
        chk_out("dbl_shown", 0, 4'h2, 1'b1, 1'b1, 1'b0);

        // Load exactly on the boundary cycle 159 goes straight to display.
        tick(31);
        chk_out("bnd_pre", 3, 4'h2, 1'b0, 1'b0, 1'b0);
        value = 16'h7777; value_load = 1'b1;
        tick(1);
        value_load = 1'b0;
        chk_out("bnd_load", 0, 4'h7, 1'b1, 1'b1, 1'b0);
        tick(1);
        chk_out("bnd_after", 0, 4'h7, 1'b1, 1'b0, 1'b0);

        // Disable at c=5 of slot 2 (cycle 181) for 20 cycles.
        tick(20);
        chk_out("dis_pre", 2, 4'h7, 1'b0, 1'b0, 1'b0);
        en = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick(1);
            chk_out($sformatf("dis%0d", k), 2, 4'h7, 1'b1, 1'b0, 1'b0);
            chk($sformatf("dis%0d.b0blank", k), 32'(bus0.blank), 32'(1));
        end
        en = 1'b1;
        tick(1);
        chk_out("resume_c6", 2, 4'h7, 1'b0, 1'b0, 1'b0);
        chk("resume.b0blank", 32'(bus0.blank), 32'(0));
        tick(1);
        chk_out("resume_c7", 2, 4'h7, 1'b0, 1'b0, 1'b0);
        tick(1);
        chk_out("resume_slot3", 3, 4'h7, 1'b1, 1'b0, 1'b0);

        // Reset mid-slot 3 with a load pending discards it.
        tick(3);
        value = 16'hBEEF; value_load = 1'b1;
        tick(1);
        value_load = 1'b0;
        chk_out("rst_pend", 3, 4'h7, 1'b0, 1'b0, 1'b1);
        rst = 1'b1;
        tick(1);
        chk_out("rst_mid", 0, 0, 1'b1, 1'b0, 1'b0);
        rst = 1'b0;
        tick(8);
        chk_out("rst_slot1", 1, 0, 1'b1, 1'b0, 1'b0);
        tick(24);
        chk_out("rst_frame", 0, 0, 1'b1, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
